// File: rtl/complex_acc_dump.sv
`default_nettype none
// ============================================================================
// Module   : complex_acc_dump
// Brief    : Integrate-and-dump accumulator for complex products, with
//            valid/ready input and output ports. COMPLEX_ACC_ROUND_EN selects
//            the rounded block average instead of the raw sum.
// Revision : 1.0 - initial release
// ============================================================================
module complex_acc_dump #(
    parameter int DIN_WIDTH = 17,
    parameter int ACC_LEN   = 16,
    localparam int LOG2_LEN  = $clog2(ACC_LEN),
    localparam int ACC_WIDTH = DIN_WIDTH + LOG2_LEN,
`ifdef COMPLEX_ACC_ROUND_EN
    localparam int OUT_WIDTH = DIN_WIDTH
`else
    localparam int OUT_WIDTH = ACC_WIDTH
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        acc_clr,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  logic signed [DIN_WIDTH-1:0] din_i,
    input  logic signed [DIN_WIDTH-1:0] din_q,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic signed [OUT_WIDTH-1:0] dout_i,
    output logic signed [OUT_WIDTH-1:0] dout_q
);

    localparam logic [LOG2_LEN-1:0] c_last_cnt = LOG2_LEN'(ACC_LEN - 1);

    logic [LOG2_LEN-1:0]         r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc_i;
    logic signed [ACC_WIDTH-1:0] r_acc_q;
    logic signed [OUT_WIDTH-1:0] r_dout_i;
    logic signed [OUT_WIDTH-1:0] r_dout_q;
    logic                        r_dout_valid;

    logic                        w_first;
    logic                        w_last;
    logic                        w_ready;
    logic                        w_accept;
    logic                        w_dump;
    logic signed [ACC_WIDTH-1:0] w_ext_i;
    logic signed [ACC_WIDTH-1:0] w_ext_q;
    logic signed [ACC_WIDTH-1:0] w_sum_i;
    logic signed [ACC_WIDTH-1:0] w_sum_q;
    logic signed [OUT_WIDTH-1:0] w_out_i;
    logic signed [OUT_WIDTH-1:0] w_out_q;

    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == c_last_cnt);

    // Only the block-completing sample waits for the output register to drain.
    assign w_ready  = ~acc_clr & (~w_last | ~r_dout_valid | dout_ready);
    assign w_accept = din_valid & w_ready;
    assign w_dump   = w_accept & w_last;

    assign w_ext_i = {{LOG2_LEN{din_i[DIN_WIDTH-1]}}, din_i};
    assign w_ext_q = {{LOG2_LEN{din_q[DIN_WIDTH-1]}}, din_q};

    // The first sample of a block loads directly, so no clear cycle is needed.
    assign w_sum_i = w_first ? w_ext_i : r_acc_i + w_ext_i;
    assign w_sum_q = w_first ? w_ext_q : r_acc_q + w_ext_q;

`ifdef COMPLEX_ACC_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] c_half = (ACC_WIDTH + 1)'(1) << (LOG2_LEN - 1);

    logic signed [ACC_WIDTH:0] w_rnd_i;
    logic signed [ACC_WIDTH:0] w_rnd_q;
    logic                      w_unused;

    // Round half up one bit wider, then the average always fits DIN_WIDTH.
    assign w_rnd_i  = {w_sum_i[ACC_WIDTH-1], w_sum_i} + c_half;
    assign w_rnd_q  = {w_sum_q[ACC_WIDTH-1], w_sum_q} + c_half;
    assign w_out_i  = w_rnd_i[LOG2_LEN +: DIN_WIDTH];
    assign w_out_q  = w_rnd_q[LOG2_LEN +: DIN_WIDTH];
    assign w_unused = &{1'b0, w_rnd_i[ACC_WIDTH], w_rnd_i[LOG2_LEN-1:0],
                              w_rnd_q[ACC_WIDTH], w_rnd_q[LOG2_LEN-1:0]};
`else
    assign w_out_i = w_sum_i;
    assign w_out_q = w_sum_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else begin
            if (acc_clr) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + LOG2_LEN'(1);
            end
            if (w_accept) begin
                r_acc_i <= w_sum_i;
                r_acc_q <= w_sum_q;
            end
        end
    end

    // A dump on the same edge as a consume keeps valid high with new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout_i     <= '0;
            r_dout_q     <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_dump) begin
            r_dout_i     <= w_out_i;
            r_dout_q     <= w_out_q;
            r_dout_valid <= 1'b1;
        end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign din_ready  = w_ready;
    assign dout_valid = r_dout_valid;
    assign dout_i     = r_dout_i;
    assign dout_q     = r_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_complex_acc_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_complex_acc_dump
// Brief    : Scoreboard bench for complex_acc_dump (DIN_WIDTH=17, ACC_LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_complex_acc_dump;

    localparam int DW  = 17;
    localparam int LEN = 4;
`ifdef COMPLEX_ACC_ROUND_EN
    localparam int OW = DW;
`else
    localparam int OW = DW + 2;
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          acc_clr    = 1'b0;
    logic          din_valid  = 1'b0;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] din_i      = '0;
    logic [DW-1:0] din_q      = '0;
    logic          din_ready;
    logic          dout_valid;
    logic [OW-1:0] dout_i;
    logic [OW-1:0] dout_q;

    int total = 0;
    int bad   = 0;

    int m_cnt = 0;
    int m_si  = 0;
    int m_sq  = 0;
    logic [2*OW-1:0] sb[$];

    complex_acc_dump #(
        .DIN_WIDTH (DW),
        .ACC_LEN   (LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .acc_clr    (acc_clr),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_i      (din_i),
        .din_q      (din_q),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_i     (dout_i),
        .dout_q     (dout_q)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] exp_out(input int s);
        int r;
`ifdef COMPLEX_ACC_ROUND_EN
        r = (s + 2) >>> 2;
`else
        r = s;
`endif
        return r[OW-1:0];
    endfunction

    // Inputs change only at posedge+1, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid && dout_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got i=%0d q=%0d want no output",
                             $signed(dout_i), $signed(dout_q));
                end else begin
                    logic [2*OW-1:0] e;
                    e = sb.pop_front();
                    if ({dout_i, dout_q} !== e) begin
                        bad++;
                        $display("FAIL sb_data got i=%0d q=%0d want i=%0d q=%0d",
                                 $signed(dout_i), $signed(dout_q),
                                 $signed(e[2*OW-1:OW]), $signed(e[OW-1:0]));
                    end
                end
            end
            if (acc_clr) begin
                m_cnt = 0;
            end else if (din_valid && din_ready) begin
                m_si  = (m_cnt == 0) ? int'($signed(din_i)) : m_si + int'($signed(din_i));
                m_sq  = (m_cnt == 0) ? int'($signed(din_q)) : m_sq + int'($signed(din_q));
                m_cnt = m_cnt + 1;
                if (m_cnt == LEN) begin
                    sb.push_back({exp_out(m_si), exp_out(m_sq)});
                    m_cnt = 0;
                end
            end
        end
    end

    always @(posedge rst) begin
        m_cnt = 0;
        sb.delete();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int i, input int q);
        din_valid = v;
        din_i     = DW'(i);
        din_q     = DW'(q);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        total += 3;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        if (dout_i !== '0) begin bad++; $display("FAIL reset_dout_i got %0d want 0", dout_i); end
        if (dout_q !== '0) begin bad++; $display("FAIL reset_dout_q got %0d want 0", dout_q); end
        rst = 1'b0;
        #1;
        total++;
        if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_din_ready got %b want 1", din_ready); end
    endtask

    task automatic test_basic();
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k + 1, -(k + 1));
            total++;
            if (din_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got %b want 1", din_ready); end
            step();
        end
        drive(1'b0, 0, 0);
        total += 3;
        if (dout_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got %b want 1", dout_valid); end
        if (dout_i !== exp_out(10)) begin bad++; $display("FAIL basic_i got %0d want %0d", $signed(dout_i), $signed(exp_out(10))); end
        if (dout_q !== exp_out(-10)) begin bad++; $display("FAIL basic_q got %0d want %0d", $signed(dout_q), $signed(exp_out(-10))); end
        step();
        total++;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got %b want 0", dout_valid); end
    endtask

    task automatic test_stream();
        int n = 0;
        int first = -1;
        int second = -1;
        dout_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 65535, -65536);
            total++;
            if (din_ready !== 1'b1) begin bad++; $display("FAIL stream_ready got %b want 1", din_ready); end
            step();
            if (dout_valid) begin
                if (n == 0) first = k;
                else if (n == 1) second = k;
                n++;
            end
        end
        drive(1'b0, 0, 0);
        total += 4;
        if (n != 2) begin bad++; $display("FAIL stream_dumps got %0d want 2", n); end
        if (second - first != 4) begin bad++; $display("FAIL stream_spacing got %0d want 4", second - first); end
        if (dout_i !== exp_out(262140)) begin bad++; $display("FAIL stream_i got %0d want %0d", $signed(dout_i), $signed(exp_out(262140))); end
        if (dout_q !== exp_out(-262144)) begin bad++; $display("FAIL stream_q got %0d want %0d", $signed(dout_q), $signed(exp_out(-262144))); end
        step();
    endtask

    task automatic test_backpressure();
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 10 * (k + 1), -5);
            step();
        end
        dout_ready = 1'b0;
        total++;
        if (dout_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid got %b want 1", dout_valid); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1, 2);
            total++;
            if (din_ready !== 1'b1) begin bad++; $display("FAIL bp_partial_ready got %b want 1", din_ready); end
            step();
            total += 2;
            if (dout_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got %b want 1", dout_valid); end
            if ({dout_i, dout_q} !== {exp_out(100), exp_out(-20)}) begin
                bad++;
                $display("FAIL bp_hold_data got i=%0d q=%0d want i=%0d q=%0d", $signed(dout_i), $signed(dout_q),
                         $signed(exp_out(100)), $signed(exp_out(-20)));
            end
        end
        drive(1'b1, 1, 2);
        for (int k = 0; k < 2; k++) begin
            total += 2;
            if (din_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got %b want 0", din_ready); end
            if (dout_i !== exp_out(100)) begin bad++; $display("FAIL bp_stall_i got %0d want %0d", $signed(dout_i), $signed(exp_out(100))); end
            step();
        end
        dout_ready = 1'b1;
        #1;
        total++;
        if (din_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", din_ready); end
        step();
        drive(1'b0, 0, 0);
        total += 3;
        if (dout_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid got %b want 1", dout_valid); end
        if (dout_i !== exp_out(4)) begin bad++; $display("FAIL bp_second_i got %0d want %0d", $signed(dout_i), $signed(exp_out(4))); end
        if (dout_q !== exp_out(8)) begin bad++; $display("FAIL bp_second_q got %0d want %0d", $signed(dout_q), $signed(exp_out(8))); end
        step();
        total++;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b want 0", dout_valid); end
    endtask

    task automatic test_clear();
        dout_ready = 1'b1;
        repeat (2) begin
            drive(1'b1, 100, 0);
            step();
        end
        acc_clr = 1'b1;
        drive(1'b1, 100, 0);
        #1;
        total++;
        if (din_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got %b want 0", din_ready); end
        step();
        acc_clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1, 0);
            step();
            total++;
            if (dout_valid !== (k == 3)) begin bad++; $display("FAIL clr_valid step %0d got %b want %b", k, dout_valid, k == 3); end
        end
        drive(1'b0, 0, 0);
        total++;
        if (dout_i !== exp_out(4)) begin bad++; $display("FAIL clr_i got %0d want %0d", $signed(dout_i), $signed(exp_out(4))); end
        step();
    endtask

    task automatic test_async_reset();
        dout_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, (k < 4) ? 3 : 5, (k < 4) ? 3 : 0);
            step();
        end
        drive(1'b0, 0, 0);
        total++;
        if (dout_valid !== 1'b1) begin bad++; $display("FAIL arst_pending got %b want 1", dout_valid); end
        #1;
        rst = 1'b1;
        #1;
        total += 3;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got %b want 0", dout_valid); end
        if (dout_i !== '0) begin bad++; $display("FAIL arst_dout_i got %0d want 0", $signed(dout_i)); end
        if (din_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got %b want 1", din_ready); end
        rst = 1'b0;
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5, 0);
            step();
            total++;
            if (dout_valid !== (k == 3)) begin bad++; $display("FAIL arst_dump step %0d got %b want %b", k, dout_valid, k == 3); end
        end
        drive(1'b0, 0, 0);
        total++;
        if (dout_i !== exp_out(20)) begin bad++; $display("FAIL arst_i got %0d want %0d", $signed(dout_i), $signed(exp_out(20))); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_clear();
        test_async_reset();
        repeat (2) step();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
